bp_me_mem_fwd_rr_arbiter: RTL and testbench
===========================================

Name: bp_me_mem_fwd_rr_arbiter

Overview:
- Shares one BedRock memory-forward (mem_fwd) stream port between num_req_p CCE/L2-bank requesters.
- Sits between the per-CCE mem_fwd outputs and the single memory-side link of an L2 expansion column.
- Round-robin grant, held for a whole multi-beat message until the last beat. Fair and starvation-free for up to 16 requesters.

Parameters:
- num_req_p, 4, number of requesters; legal range 1..16.
- hdr_width_p, 72, mem_fwd header width in bits (mem_fwd_header_width_lp).
- data_width_p, 64, stream beat data width (bedrock_data_width_p).
- lg_num_req_lp, `BSG_SAFE_CLOG2(num_req_p), derived width of the grant index.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset, synchronous, active-low.
- req_header_i  in  num_req_p*hdr_width_p  per-requester header; stable for the whole message.
- req_data_i  in  num_req_p*data_width_p  per-requester beat data.
- req_v_i  in  num_req_p  per-requester beat valid.
- req_last_i  in  num_req_p  marks the final beat of the message.
- req_ready_and_o  out  num_req_p  per-requester beat accepted (valid&ready handshake).
- mem_header_o  out  hdr_width_p  header of the granted requester.
- mem_data_o  out  data_width_p  data of the granted requester.
- mem_v_o  out  1  output beat valid.
- mem_last_o  out  1  output last beat.
- mem_ready_and_i  in  1  downstream ready.
- grant_id_o  out  lg_num_req_lp  index of the current or locked requester, for response routing.
- busy_o  out  1  high while locked mid-message.

Behaviour:
- Clock and reset: single clock clk_i. reset_n_i is synchronous and active-low.
- Reset values, while reset_n_i=0:
  - mem_v_o=0, req_ready_and_o=0, busy_o=0, grant_id_o=0.
  - FSM=e_idle, rr pointer ptr_r=0.
- FSM state e_idle:
  - sel = first i with req_v_i[i]=1, scanning ptr_r, ptr_r+1, …, wrapping modulo num_req_p.
  - The selected beat is passed through combinationally in the same cycle (zero latency).
  - Outputs: mem_v_o=|req_v_i; mem_* muxed from sel; req_ready_and_o = onehot(sel) & {num_req_p{mem_ready_and_i}}; grant_id_o=sel.
  - If no request is valid: mem_v_o=0, grant_id_o holds its last value, and state and pointer are unchanged.
  - Handshake with req_last_i[sel]=1: stay in e_idle; ptr_r <= (sel+1) mod num_req_p.
  - Handshake with req_last_i[sel]=0: go to e_busy; lock_r <= sel.
- FSM state e_busy:
  - Only lock_r is muxed; grant_id_o=lock_r; busy_o=1. All other requesters see ready=0 regardless of their valid.
  - If req_v_i[lock_r] drops: mem_v_o=0 and the lock is held (bubble allowed).
  - Handshake with last: go to e_idle; ptr_r <= (lock_r+1) mod num_req_p.
- Backpressure: with mem_ready_and_i=0 there is no handshake. State and pointer hold, and the selection in e_idle may change only if a requester's valid changes.
- num_req_p=1: the pointer is constant 0. The block degenerates to a pass-through that still tracks busy_o.
- Reset mid-message: returns to e_idle with ptr_r=0 next cycle. The partial message is dropped; the upstream reset is required to flush the requester.
- Assertions (nonsynth):
  - num_req_p<=16.
  - Header unchanged across beats of a locked message.
  - req_v_i[lock_r] is not expected to drop while busy; this is a warning, not an error.

Decomposition:
- bp_me_pkg: typedef enum logic {e_arb_idle, e_arb_busy} bp_me_arb_state_e.
- Header struct: reuse the existing bp_bedrock_mem_fwd_header_s via the declare macro.
- Sub-module bp_me_rr_pick: combinational rotating priority encoder.
  - Inputs: req vector, ptr.
  - Outputs: onehot grant, index, any_v.
  - Reused by other BedRock arbiters.

Test Plan:
- Single request: req_v_i=4'b0010, 1-beat message, ready=1 → same-cycle mem_v_o=1, grant_id_o=1, req_ready_and_o=4'b0010, ptr_r becomes 2.
- All 4 requesters continuously valid with 1-beat messages → grants in order 0,1,2,3,0,… and no requester is skipped.
- Requester 2 sends 4 beats while 0 and 3 are valid → 4 consecutive beats from 2 with busy_o=1 on beats 2–4. Then grant goes to 3, then 0.
- Locked requester 1 drops valid for 3 cycles mid-message → mem_v_o=0 for 3 cycles, grant stays 1, no other requester is granted.
- mem_ready_and_i=0 for 5 cycles with requester 0 valid → no handshake, ptr_r unchanged, req_ready_and_o=0. The beat transfers on the first ready cycle.
- Assert reset_n_i=0 on beat 2 of a 4-beat message → next cycle: busy_o=0, ptr_r=0, mem_v_o=0 during reset. The first grant after reset is the lowest valid index.

Source files
------------

// File: rtl/bp_me_mem_fwd_rr_arbiter_pkg.sv
// Shared types and helpers for the BedRock mem_fwd round-robin arbiter.
package bp_me_mem_fwd_rr_arbiter_pkg;

  typedef enum logic {e_arb_idle, e_arb_busy} bp_me_arb_state_e;

  localparam int unsigned max_req_lp = 16;

  // Index width that stays at least one bit wide for a single requester.
  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bp_me_mem_fwd_rr_arbiter_pick.sv
// Combinational rotating priority encoder: first valid request at or after ptr_i, wrapping.
module bp_me_mem_fwd_rr_arbiter_pick
  import bp_me_mem_fwd_rr_arbiter_pkg::*;
#(
  parameter int unsigned num_req_p = 4,
  localparam int unsigned lg_lp = safe_clog2(num_req_p)
) (
  input  logic [num_req_p-1:0] req_i,
  input  logic [lg_lp-1:0]     ptr_i,
  output logic [num_req_p-1:0] grant_onehot_o,
  output logic [lg_lp-1:0]     grant_idx_o,
  output logic                 any_v_o
);

  int unsigned      pos;
  logic [lg_lp-1:0] pos_idx;

  always_comb begin
    grant_onehot_o = '0;
    grant_idx_o    = '0;
    any_v_o        = 1'b0;
    pos            = 0;
    pos_idx        = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      pos     = (32'(ptr_i) + i) % num_req_p;
      pos_idx = lg_lp'(pos);
      if (!any_v_o && req_i[pos_idx]) begin
        any_v_o                 = 1'b1;
        grant_idx_o             = pos_idx;
        grant_onehot_o[pos_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bp_me_mem_fwd_rr_arbiter.sv
// Round-robin arbiter sharing one mem_fwd stream link; the grant is held until the last beat.
module bp_me_mem_fwd_rr_arbiter
  import bp_me_mem_fwd_rr_arbiter_pkg::*;
#(
  parameter int unsigned num_req_p    = 4,
  parameter int unsigned hdr_width_p  = 72,
  parameter int unsigned data_width_p = 64,
  localparam int unsigned lg_num_req_lp = safe_clog2(num_req_p)
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_req_p*hdr_width_p-1:0]  req_header_i,
  input  logic [num_req_p*data_width_p-1:0] req_data_i,
  input  logic [num_req_p-1:0]              req_v_i,
  input  logic [num_req_p-1:0]              req_last_i,
  output logic [num_req_p-1:0]              req_ready_and_o,
  output logic [hdr_width_p-1:0]            mem_header_o,
  output logic [data_width_p-1:0]           mem_data_o,
  output logic                              mem_v_o,
  output logic                              mem_last_o,
  input  logic                              mem_ready_and_i,
  output logic [lg_num_req_lp-1:0]          grant_id_o,
  output logic                              busy_o
);

  if (num_req_p < 1 || num_req_p > max_req_lp) begin : g_bad_num_req
    $error("num_req_p must be within 1..16");
  end

  bp_me_arb_state_e           state_r, state_n;
  logic [lg_num_req_lp-1:0]   ptr_r, ptr_n;
  logic [lg_num_req_lp-1:0]   lock_r, lock_n;
  logic [lg_num_req_lp-1:0]   grant_r, grant_n;
  logic [lg_num_req_lp-1:0]   cur_idx;
  logic [num_req_p-1:0]       sel_onehot, lock_onehot;
  logic [lg_num_req_lp-1:0]   sel_idx;
  logic                       sel_any;

  function automatic logic [lg_num_req_lp-1:0] next_idx(input logic [lg_num_req_lp-1:0] idx);
    return (32'(idx) + 1 >= num_req_p) ? '0 : idx + lg_num_req_lp'(1);
  endfunction

  bp_me_mem_fwd_rr_arbiter_pick #(.num_req_p(num_req_p)) pick (
    .req_i          (req_v_i),
    .ptr_i          (ptr_r),
    .grant_onehot_o (sel_onehot),
    .grant_idx_o    (sel_idx),
    .any_v_o        (sel_any)
  );

  assign lock_onehot = num_req_p'(1) << lock_r;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= e_arb_idle;
      ptr_r   <= '0;
      lock_r  <= '0;
      grant_r <= '0;
    end else begin
      state_r <= state_n;
      ptr_r   <= ptr_n;
      lock_r  <= lock_n;
      grant_r <= grant_n;
    end
  end

  // Next state plus the zero-latency beat mux; reset forces the link quiet.
  always_comb begin
    state_n         = state_r;
    ptr_n           = ptr_r;
    lock_n          = lock_r;
    grant_n         = grant_r;
    cur_idx         = sel_idx;
    mem_v_o         = 1'b0;
    req_ready_and_o = '0;
    busy_o          = 1'b0;
    grant_id_o      = grant_r;
    case (state_r)
      e_arb_idle: begin
        cur_idx         = sel_idx;
        mem_v_o         = sel_any;
        req_ready_and_o = sel_onehot & {num_req_p{mem_ready_and_i}};
        if (sel_any) begin
          grant_id_o = sel_idx;
          grant_n    = sel_idx;
          if (mem_ready_and_i) begin
            if (req_last_i[sel_idx]) begin
              ptr_n = next_idx(sel_idx);
            end else begin
              state_n = e_arb_busy;
              lock_n  = sel_idx;
            end
          end
        end
      end
      e_arb_busy: begin
        cur_idx         = lock_r;
        mem_v_o         = req_v_i[lock_r];
        req_ready_and_o = lock_onehot & {num_req_p{mem_ready_and_i}};
        busy_o          = 1'b1;
        grant_id_o      = lock_r;
        grant_n         = lock_r;
        if (req_v_i[lock_r] && mem_ready_and_i && req_last_i[lock_r]) begin
          state_n = e_arb_idle;
          ptr_n   = next_idx(lock_r);
        end
      end
    endcase
    if (!reset_n_i) begin
      mem_v_o         = 1'b0;
      req_ready_and_o = '0;
      busy_o          = 1'b0;
      grant_id_o      = '0;
    end
    mem_last_o   = req_last_i[cur_idx];
    mem_header_o = req_header_i[32'(cur_idx)*hdr_width_p +: hdr_width_p];
    mem_data_o   = req_data_i[32'(cur_idx)*data_width_p +: data_width_p];
  end

  // A locked requester is expected to keep streaming; a bubble is tolerated.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && state_r == e_arb_busy) begin
      assert (req_v_i[lock_r])
        else $warning("locked requester %0d deasserted valid mid-message", lock_r);
    end
  end

  assert property (@(posedge clk_i) disable iff (!reset_n_i)
                   (state_r == e_arb_busy) |-> $stable(mem_header_o))
    else $error("header changed during a locked message");

endmodule

// File: tb/tb_bp_me_mem_fwd_rr_arbiter.sv
// Directed cycle-table bench for the mem_fwd round-robin arbiter.
module tb_bp_me_mem_fwd_rr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned HW = 72;
  localparam int unsigned DW = 64;
  localparam int unsigned LW = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N*HW-1:0]   req_header;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_v;
  logic [N-1:0]      req_last;
  logic [N-1:0]      req_ready_and;
  logic [HW-1:0]     mem_header;
  logic [DW-1:0]     mem_data;
  logic              mem_v;
  logic              mem_last;
  logic              mem_ready_and;
  logic [LW-1:0]     grant_id;
  logic              busy;

  always #5 clk = ~clk;

  bp_me_mem_fwd_rr_arbiter #(.num_req_p(N), .hdr_width_p(HW), .data_width_p(DW)) dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .req_header_i    (req_header),
    .req_data_i      (req_data),
    .req_v_i         (req_v),
    .req_last_i      (req_last),
    .req_ready_and_o (req_ready_and),
    .mem_header_o    (mem_header),
    .mem_data_o      (mem_data),
    .mem_v_o         (mem_v),
    .mem_last_o      (mem_last),
    .mem_ready_and_i (mem_ready_and),
    .grant_id_o      (grant_id),
    .busy_o          (busy)
  );

  typedef struct {
    logic          rst_n;
    logic [N-1:0]  v;
    logic [N-1:0]  last;
    logic          rdy;
    logic          mv;
    logic [N-1:0]  ordy;
    logic [LW-1:0] gid;
    logic          busy;
    logic [LW-1:0] ptr;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic rst_n, input logic [N-1:0] v, input logic [N-1:0] last,
                              input logic rdy, input logic mv, input logic [N-1:0] ordy,
                              input logic [LW-1:0] gid, input logic bsy, input logic [LW-1:0] ptr);
    vec_t r;
    r.rst_n = rst_n; r.v = v; r.last = last; r.rdy = rdy;
    r.mv = mv; r.ordy = ordy; r.gid = gid; r.busy = bsy; r.ptr = ptr;
    return r;
  endfunction

  task automatic chk(input string name, input int tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, tag, act, exp);
    end
  endtask

  task automatic drive(input vec_t r, input int tag);
    reset_n       = r.rst_n;
    req_v         = r.v;
    req_last      = r.last;
    mem_ready_and = r.rdy;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'(tag*16 + i);
  endtask

  // One cycle: drive after the edge, compare at the falling edge.
  task automatic step(input vec_t r, input int tag, input logic chk_ptr);
    logic [N-1:0] l;
    @(posedge clk);
    #1;
    drive(r, tag);
    @(negedge clk);
    l = r.last;
    chk("mem_v", tag, 128'(mem_v), 128'(r.mv));
    chk("ready", tag, 128'(req_ready_and), 128'(r.ordy));
    chk("grant_id", tag, 128'(grant_id), 128'(r.gid));
    chk("busy", tag, 128'(busy), 128'(r.busy));
    if (chk_ptr) chk("ptr", tag, 128'(dut.ptr_r), 128'(r.ptr));
    if (r.mv) begin
      chk("mem_last", tag, 128'(mem_last), 128'(l[r.gid]));
      chk("mem_data", tag, 128'(mem_data), 128'(DW'(tag*16 + 32'(r.gid))));
      chk("mem_header", tag, 128'(mem_header), 128'(HW'(32'hA0 + 32'(r.gid))));
    end
  endtask

  initial begin
    int exp_g;
    for (int i = 0; i < N; i++) req_header[i*HW +: HW] = HW'(32'hA0 + i);
    req_data = '0;
    drive(mk(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd0), 0);
    repeat (2) @(posedge clk);

    //            rst   v        last     rdy   mv    ordy     gid   busy  ptr
    tbl.push_back(mk(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd0));
    tbl.push_back(mk(1'b1, 4'b0010, 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0, 2'd0));
    tbl.push_back(mk(1'b1, 4'b0000, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b0, 2'd2));
    tbl.push_back(mk(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b0, 2'd2));
    tbl.push_back(mk(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b0, 2'd3));
    tbl.push_back(mk(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 2'd0));
    tbl.push_back(mk(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0, 2'd1));
    tbl.push_back(mk(1'b1, 4'b1101, 4'b1011, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b0, 2'd2));
    tbl.push_back(mk(1'b1, 4'b1101, 4'b1011, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 2'd2));
    tbl.push_back(mk(1'b1, 4'b1101, 4'b1011, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 2'd2));
    tbl.push_back(mk(1'b1, 4'b1101, 4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 2'd2));
    tbl.push_back(mk(1'b1, 4'b1001, 4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b0, 2'd3));
    tbl.push_back(mk(1'b1, 4'b1001, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 2'd0));
    tbl.push_back(mk(1'b1, 4'b1111, 4'b1101, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0, 2'd1));
    tbl.push_back(mk(1'b1, 4'b1101, 4'b1101, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1, 2'd1));
    tbl.push_back(mk(1'b1, 4'b1101, 4'b1101, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1, 2'd1));
    tbl.push_back(mk(1'b1, 4'b1101, 4'b1101, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1, 2'd1));
    tbl.push_back(mk(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 2'd1));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1'b1, 4'b0001, 4'b1111, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd2));
    tbl.push_back(mk(1'b1, 4'b0001, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 2'd2));
    tbl.push_back(mk(1'b1, 4'b0000, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd1));
    tbl.push_back(mk(1'b1, 4'b1100, 4'b0000, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b0, 2'd1));
    tbl.push_back(mk(1'b0, 4'b1100, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd1));
    tbl.push_back(mk(1'b1, 4'b1010, 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0, 2'd0));

    for (int k = 0; k < tbl.size(); k++) step(tbl[k], k, 1'b1);

    // Saturated single-beat traffic must rotate strictly from the pointer left by the table.
    exp_g = 2;
    for (int k = 0; k < 8; k++) begin
      step(mk(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'(1 << exp_g), LW'(exp_g), 1'b0, LW'(exp_g)),
           100 + k, 1'b1);
      exp_g = (exp_g + 1) % N;
    end

    // Backpressure inside a locked message keeps the lock and blocks everyone.
    step(mk(1'b1, 4'b1111, 4'b1011, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b0, 2'd2), 200, 1'b1);
    step(mk(1'b1, 4'b1111, 4'b1011, 1'b0, 1'b1, 4'b0000, 2'd2, 1'b1, 2'd2), 201, 1'b1);
    step(mk(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 2'd2), 202, 1'b1);
    step(mk(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b0, 2'd3), 203, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
